gpio_stream_reader: RTL and testbench

//  Parametrised CPU readback bridge over the 32-bit GPIO pair. It drains NUM_CH AXI-stream channels
//  of CH_WIDTH bits each (A/C FIFOs, MAC/NL ADC streams) as 32-bit beats, and exposes NUM_STAT
//  32-bit status words. It adds a bridge status register, a saturating underrun counter and a

---
 rtl/gpio_stream_reader_pkg.sv | 33 +++
 rtl/gpio_stream_reader_if.sv | 9 +
 rtl/gpio_stream_reader.sv | 187 ++++++++++++++++++
 tb/tb_gpio_stream_reader.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_stream_reader_pkg.sv
// Shared configuration for the GPIO stream readback bridge: GPIO word layout,
// default address map, FSM state type and small elaboration helpers.
package gpio_stream_reader_pkg;

  // GPIO word layout agreed with the PS side (ising_config)
  localparam int unsigned GPIO_W_CLK_BIT   = 31;
  localparam int unsigned GPIO_ADDR_START  = 7;
  localparam int unsigned GPIO_ADDR_END    = 0;
  localparam int unsigned GPIO_ADDR_WIDTH  = GPIO_ADDR_START - GPIO_ADDR_END + 1;

  // Default address map
  localparam int unsigned DEF_STREAM_BASE  = 'h10;
  localparam int unsigned DEF_STAT_BASE    = 'h20;
  localparam int unsigned DEF_BSTAT_ADDR   = 'h30;
  localparam int unsigned DEF_FLUSH_ADDR   = 'h31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Number of 32-bit beats needed to carry a stream word of the given width
  function automatic int unsigned beats_of(input int unsigned width);
    return (width + 31) / 32;
  endfunction

  // True when [a_lo, a_lo+a_n) and [b_lo, b_lo+b_n) share any address
  function automatic bit ranges_overlap(input int unsigned a_lo, input int unsigned a_n,
                                        input int unsigned b_lo, input int unsigned b_n);
    return (a_lo < b_lo + b_n) && (b_lo < a_lo + a_n);
  endfunction

endpackage

// File: rtl/gpio_stream_reader_if.sv
// CPU-facing GPIO pair: request word in, read data and read-success flag out.
interface gpio_stream_reader_if;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        valid;

  modport master (output gpio_in, input gpio_out, input valid);
  modport slave  (input gpio_in, output gpio_out, output valid);
endinterface

// File: rtl/gpio_stream_reader.sv
// CPU readback bridge: drains NUM_CH AXI-stream channels as 32-bit beats over
// the GPIO pair, exposes status words, a bridge status register with a
// saturating underrun counter, and a flush command.
module gpio_stream_reader
  import gpio_stream_reader_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CH_WIDTH    = 128,
  parameter int unsigned NUM_STAT    = 8,
  parameter int unsigned STREAM_BASE = DEF_STREAM_BASE,
  parameter int unsigned STAT_BASE   = DEF_STAT_BASE,
  parameter int unsigned BSTAT_ADDR  = DEF_BSTAT_ADDR,
  parameter int unsigned FLUSH_ADDR  = DEF_FLUSH_ADDR
) (
  input  logic                         clk,
  input  logic                         rst,
  gpio_stream_reader_if.slave          bus,
  input  logic [NUM_CH*CH_WIDTH-1:0]   s_data,
  input  logic [NUM_CH-1:0]            s_valid,
  output logic [NUM_CH-1:0]            s_ready,
  input  logic [NUM_STAT*32-1:0]       stat_in
);

  localparam int unsigned BEATS = beats_of(CH_WIDTH);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PAD_W = BEATS * 32;
  localparam int unsigned AW    = GPIO_ADDR_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam bit ADDR_CLASH =
      ranges_overlap(STREAM_BASE, NUM_CH, STAT_BASE, NUM_STAT) ||
      ranges_overlap(STREAM_BASE, NUM_CH, BSTAT_ADDR, 1)       ||
      ranges_overlap(STREAM_BASE, NUM_CH, FLUSH_ADDR, 1)       ||
      ranges_overlap(STAT_BASE, NUM_STAT, BSTAT_ADDR, 1)       ||
      ranges_overlap(STAT_BASE, NUM_STAT, FLUSH_ADDR, 1)       ||
      ranges_overlap(BSTAT_ADDR, 1, FLUSH_ADDR, 1);

  if (ADDR_CLASH || NUM_CH < 1 || NUM_CH > 16) begin : g_bad_cfg
    $error("gpio_stream_reader: overlapping address ranges or NUM_CH outside 1..16");
  end

  state_t                         state, state_nxt;
  logic [31:0]                    data_reg, data_nxt;
  logic                           rd_ok, rd_ok_nxt;
  logic [NUM_CH-1:0]              ready_nxt;
  logic [NUM_CH-1:0][CNT_W-1:0]   beat_cnt, beat_nxt;
  logic [15:0]                    underrun_cnt, under_nxt;

  logic                           w_clk;
  logic [AW-1:0]                  addr;
  logic [NUM_CH-1:0]              ch_hit;
  logic                           stream_hit, stat_hit;
  logic [31:0]                    stat_word, bstat_word;
  logic [NUM_CH-1:0][31:0]        beat_word;
  logic                           unused_gpio_bits;

  assign w_clk            = bus.gpio_in[GPIO_W_CLK_BIT];
  assign addr             = bus.gpio_in[GPIO_ADDR_START:GPIO_ADDR_END];
  assign unused_gpio_bits = ^bus.gpio_in;

  // Select the 32-bit slice of a zero-padded stream word for a beat index
  function automatic logic [31:0] pick_beat(input logic [PAD_W-1:0] word,
                                            input logic [CNT_W-1:0] idx);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (idx == CNT_W'(b)) r = word[b*32 +: 32];
    end
    return r;
  endfunction

  // Per-channel current beat, last beat zero-padded in its MSBs
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PAD_W-1:0] padded;
    if (PAD_W > CH_WIDTH) begin : g_pad
      assign padded = {{(PAD_W - CH_WIDTH){1'b0}}, s_data[k*CH_WIDTH +: CH_WIDTH]};
    end else begin : g_exact
      assign padded = s_data[k*CH_WIDTH +: CH_WIDTH];
    end
    assign beat_word[k] = pick_beat(padded, beat_cnt[k]);
  end

  // Address decode for stream channels and status words
  always_comb begin
    ch_hit    = '0;
    stat_hit  = 1'b0;
    stat_word = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_hit[k] = (addr == AW'(STREAM_BASE + k));
    end
    for (int unsigned i = 0; i < NUM_STAT; i++) begin
      if (addr == AW'(STAT_BASE + i)) begin
        stat_hit  = 1'b1;
        stat_word = stat_in[i*32 +: 32];
      end
    end
  end

  assign stream_hit = |ch_hit;

  // Bridge status word: underrun count on top, live channel valids at the bottom
  always_comb begin
    bstat_word                = '0;
    bstat_word[31:16]         = underrun_cnt;
    bstat_word[NUM_CH-1:0]    = s_valid;
  end

  // Read data mux; valid only qualifies stream reads
  always_comb begin
    bus.gpio_out = '0;
    bus.valid    = 1'b1;
    if (stream_hit) begin
      bus.gpio_out = data_reg;
      bus.valid    = rd_ok;
    end else if (stat_hit) begin
      bus.gpio_out = stat_word;
    end else if (addr == AW'(BSTAT_ADDR)) begin
      bus.gpio_out = bstat_word;
    end
  end

  // Request FSM: one request per w_clk high period, serviced on entry to HOLD
  always_comb begin
    state_nxt = state;
    data_nxt  = data_reg;
    rd_ok_nxt = rd_ok;
    ready_nxt = '0;
    beat_nxt  = beat_cnt;
    under_nxt = underrun_cnt;
    case (state)
      ST_IDLE: begin
        if (w_clk) begin
          state_nxt = ST_HOLD;
          if (addr == AW'(FLUSH_ADDR)) begin
            beat_nxt  = '0;
            under_nxt = '0;
            rd_ok_nxt = 1'b1;
          end
          for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_hit[k]) begin
              if (s_valid[k]) begin
                data_nxt  = beat_word[k];
                rd_ok_nxt = 1'b1;
                if (beat_cnt[k] == LAST_BEAT) begin
                  ready_nxt[k] = 1'b1;
                  beat_nxt[k]  = '0;
                end else begin
                  beat_nxt[k]  = beat_cnt[k] + 1'b1;
                end
              end else begin
                rd_ok_nxt = 1'b0;
                if (underrun_cnt != '1) under_nxt = underrun_cnt + 1'b1;
              end
            end
          end
        end
      end
      ST_HOLD: begin
        if (!w_clk) begin
          state_nxt = ST_IDLE;
          rd_ok_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      data_reg     <= '0;
      rd_ok        <= 1'b0;
      s_ready      <= '0;
      beat_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      state        <= state_nxt;
      data_reg     <= data_nxt;
      rd_ok        <= rd_ok_nxt;
      s_ready      <= ready_nxt;
      beat_cnt     <= beat_nxt;
      underrun_cnt <= under_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_stream_reader.sv
// Self-checking bench for gpio_stream_reader: a 4x128-bit instance driven by
// a beat-position reference model, plus a 2x40-bit instance for padding.
module tb_gpio_stream_reader;
  import gpio_stream_reader_pkg::*;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gpio_stream_reader_if bus_a ();
  gpio_stream_reader_if bus_b ();

  logic [4*128-1:0] s_data_a;
  logic [3:0]       s_valid_a, s_ready_a;
  logic [8*32-1:0]  stat_a;
  logic [2*40-1:0]  s_data_b;
  logic [1:0]       s_valid_b, s_ready_b;
  logic [31:0]      stat_b;

  gpio_stream_reader #(.NUM_CH(4), .CH_WIDTH(128), .NUM_STAT(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .s_data(s_data_a), .s_valid(s_valid_a), .s_ready(s_ready_a), .stat_in(stat_a)
  );

  gpio_stream_reader #(.NUM_CH(2), .CH_WIDTH(40), .NUM_STAT(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .s_data(s_data_b), .s_valid(s_valid_b), .s_ready(s_ready_b), .stat_in(stat_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model state for dut_a
  logic [127:0] word_a [4];
  bit           pres_a [4];
  int           pos_a  [4];
  int           under_m;
  logic [31:0]  last_a;

  function automatic logic [31:0] gword(input bit wclk, input logic [7:0] a);
    logic [31:0] g;
    g = '0;
    g[GPIO_W_CLK_BIT] = wclk;
    g[GPIO_ADDR_START:GPIO_ADDR_END] = a;
    return g;
  endfunction

  task automatic drive_a();
    for (int k = 0; k < 4; k++) begin
      s_data_a[k*128 +: 128] = word_a[k];
      s_valid_a[k]           = pres_a[k];
    end
  endtask

  task automatic new_word_a(input int k, input bit p);
    word_a[k] = {$urandom, $urandom, $urandom, $urandom};
    pres_a[k] = p;
    drive_a();
  endtask

  // Expected outcome of one stream read request on dut_a
  task automatic model_a(input int k, output logic [31:0] ed, output logic ev,
                         output logic [3:0] er, output bit consumed);
    logic [127:0] w;
    er = '0;
    consumed = 1'b0;
    if (pres_a[k]) begin
      w  = word_a[k];
      ed = w[pos_a[k]*32 +: 32];
      ev = 1'b1;
      last_a = ed;
      pos_a[k]++;
      if (pos_a[k] == NB) begin
        pos_a[k] = 0;
        er[k] = 1'b1;
        consumed = 1'b1;
      end
    end else begin
      ed = last_a;
      ev = 1'b0;
      if (under_m < 65535) under_m++;
    end
  endtask

  task automatic model_flush();
    for (int k = 0; k < 4; k++) pos_a[k] = 0;
    under_m = 0;
  endtask

  function automatic logic [31:0] exp_bstat();
    logic [31:0] e;
    e = '0;
    e[31:16] = under_m[15:0];
    for (int k = 0; k < 4; k++) e[k] = pres_a[k];
    return e;
  endfunction

  // One w_clk pulse; samples just after the servicing edge. Starts/ends at negedge.
  task automatic read_x(input bit sel_b, input logic [7:0] addr, output logic [31:0] d,
                        output logic v, output logic [3:0] r);
    if (sel_b) bus_b.gpio_in = gword(1'b1, addr);
    else       bus_a.gpio_in = gword(1'b1, addr);
    @(posedge clk); #1;
    d = sel_b ? bus_b.gpio_out : bus_a.gpio_out;
    v = sel_b ? bus_b.valid    : bus_a.valid;
    r = sel_b ? {2'b00, s_ready_b} : s_ready_a;
    @(negedge clk);
    if (sel_b) bus_b.gpio_in = gword(1'b0, addr);
    else       bus_a.gpio_in = gword(1'b0, addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold w_clk high for ncyc cycles and count s_ready[k] high samples
  task automatic hold_a(input logic [7:0] addr, input int ncyc, input int k,
                        output logic [31:0] d, output logic v, output int pulses);
    pulses = 0;
    bus_a.gpio_in = gword(1'b1, addr);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        d = bus_a.gpio_out;
        v = bus_a.valid;
      end
      if (s_ready_a[k]) pulses++;
    end
    @(negedge clk);
    bus_a.gpio_in = gword(1'b0, addr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid_a = '0; s_data_a = '0; s_valid_b = '0; s_data_b = '0;
    bus_a.gpio_in = gword(1'b0, 8'h10);
    bus_b.gpio_in = gword(1'b0, 8'h10);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus_a.gpio_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", bus_a.gpio_out, 32'h0); end
    checks++; if (bus_a.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus_a.valid); end
    checks++; if (s_ready_a !== 4'h0 || s_ready_b !== 2'h0) begin errors++; $display("FAIL reset_ready: got %b/%b expected 0", s_ready_a, s_ready_b); end
    bus_a.gpio_in = gword(1'b0, 8'h30);
    #1;
    checks++; if (bus_a.gpio_out !== 32'h0) begin errors++; $display("FAIL reset_bstat: got %h expected %h", bus_a.gpio_out, 32'h0); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    under_m = 0; last_a = '0;
    for (int k = 0; k < 4; k++) begin pos_a[k] = 0; new_word_a(k, 1'b1); end
  endtask

  task automatic test_single_channel_beats();
    logic [31:0] d, ed; logic v, ev; logic [3:0] r, er; bit cons;
    word_a[1] = 128'h44444444_33333333_22222222_11111111;
    pres_a[1] = 1'b1;
    drive_a();
    for (int i = 0; i < 4; i++) begin
      model_a(1, ed, ev, er, cons);
      read_x(1'b0, 8'h11, d, v, r);
      checks++; if (d !== 32'h11111111 * (i + 1)) begin errors++; $display("FAIL t1_data[%0d]: got %h expected %h", i, d, 32'h11111111 * (i + 1)); end
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL t1_valid[%0d]: got %b expected 1", i, v); end
      checks++; if (r !== ((i == 3) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL t1_ready[%0d]: got %b expected %b", i, r, (i == 3) ? 4'b0010 : 4'b0000); end
      if (cons) new_word_a(1, 1'b1);
    end
  endtask

  task automatic test_underrun();
    logic [31:0] d, ed; logic v, ev; logic [3:0] r, er; bit cons;
    pres_a[0] = 1'b0;
    drive_a();
    for (int i = 0; i < 3; i++) begin
      model_a(0, ed, ev, er, cons);
      read_x(1'b0, 8'h10, d, v, r);
      checks++; if (v !== 1'b0) begin errors++; $display("FAIL t2_valid[%0d]: got %b expected 0", i, v); end
      checks++; if (d !== ed) begin errors++; $display("FAIL t2_held[%0d]: got %h expected %h", i, d, ed); end
    end
    bus_a.gpio_in = gword(1'b0, 8'h30);
    #1;
    checks++; if (bus_a.gpio_out[31:16] !== 16'd3) begin errors++; $display("FAIL t2_underrun: got %0d expected 3", bus_a.gpio_out[31:16]); end
    checks++; if (bus_a.gpio_out !== exp_bstat()) begin errors++; $display("FAIL t2_bstat: got %h expected %h", bus_a.gpio_out, exp_bstat()); end
    @(negedge clk);
    new_word_a(0, 1'b1);
    model_a(0, ed, ev, er, cons);
    read_x(1'b0, 8'h10, d, v, r);
    checks++; if (d !== word_a[0][31:0] || v !== 1'b1) begin errors++; $display("FAIL t2_beat0: got %h/%b expected %h/1", d, v, word_a[0][31:0]); end
  endtask

  task automatic test_flush();
    logic [31:0] d, ed; logic v, ev; logic [3:0] r, er; bit cons;
    new_word_a(2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      model_a(2, ed, ev, er, cons);
      read_x(1'b0, 8'h12, d, v, r);
      checks++; if (d !== ed) begin errors++; $display("FAIL t3_pre[%0d]: got %h expected %h", i, d, ed); end
    end
    model_flush();
    read_x(1'b0, 8'h31, d, v, r);
    checks++; if (v !== 1'b1 || d !== 32'h0 || r !== 4'h0) begin errors++; $display("FAIL t3_flush: got %h/%b/%b expected 0/1/0", d, v, r); end
    model_a(2, ed, ev, er, cons);
    read_x(1'b0, 8'h12, d, v, r);
    checks++; if (d !== word_a[2][31:0]) begin errors++; $display("FAIL t3_restart: got %h expected %h", d, word_a[2][31:0]); end
    bus_a.gpio_in = gword(1'b0, 8'h30);
    #1;
    checks++; if (bus_a.gpio_out[31:16] !== 16'd0) begin errors++; $display("FAIL t3_underrun: got %0d expected 0", bus_a.gpio_out[31:16]); end
    @(negedge clk);
  endtask

  task automatic test_width40();
    logic [31:0] d; logic v; logic [3:0] r; logic [39:0] w;
    s_data_b[39:0] = 40'hAB_12345678;
    s_valid_b = 2'b11;
    read_x(1'b1, 8'h10, d, v, r);
    checks++; if (d !== 32'h12345678 || r !== 4'h0) begin errors++; $display("FAIL t4_beat0: got %h/%b expected 12345678/0", d, r); end
    read_x(1'b1, 8'h10, d, v, r);
    checks++; if (d !== 32'h000000AB || r !== 4'b0001) begin errors++; $display("FAIL t4_beat1: got %h/%b expected 000000ab/0001", d, r); end
    for (int n = 0; n < 3; n++) begin
      w = {$urandom_range(0, 255), $urandom};
      s_data_b[79:40] = w;
      read_x(1'b1, 8'h11, d, v, r);
      checks++; if (d !== w[31:0] || r !== 4'h0) begin errors++; $display("FAIL t4_rnd0[%0d]: got %h/%b expected %h/0", n, d, r, w[31:0]); end
      read_x(1'b1, 8'h11, d, v, r);
      checks++; if (d !== {24'h0, w[39:32]} || r !== 4'b0010) begin errors++; $display("FAIL t4_rnd1[%0d]: got %h/%b expected %h/0010", n, d, r, {24'h0, w[39:32]}); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] d, ed; logic v, ev; logic [3:0] r, er; bit cons; int pulses;
    model_a(3, ed, ev, er, cons);
    hold_a(8'h13, 10, 3, d, v, pulses);
    checks++; if (d !== ed || pulses != 0) begin errors++; $display("FAIL t5_hold_mid: got %h/%0d expected %h/0", d, pulses, ed); end
    while (pos_a[3] != NB - 1) begin
      model_a(3, ed, ev, er, cons);
      read_x(1'b0, 8'h13, d, v, r);
      checks++; if (d !== ed) begin errors++; $display("FAIL t5_pre: got %h expected %h", d, ed); end
    end
    model_a(3, ed, ev, er, cons);
    hold_a(8'h13, 10, 3, d, v, pulses);
    checks++; if (pulses != 1) begin errors++; $display("FAIL t5_ready_width: got %0d expected 1", pulses); end
    checks++; if (d !== ed || v !== 1'b1) begin errors++; $display("FAIL t5_last: got %h/%b expected %h/1", d, v, ed); end
    if (cons) new_word_a(3, 1'b1);
    model_a(3, ed, ev, er, cons);
    read_x(1'b0, 8'h13, d, v, r);
    checks++; if (d !== word_a[3][31:0]) begin errors++; $display("FAIL t5_next_word: got %h expected %h", d, word_a[3][31:0]); end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] d, ed; logic v, ev; logic [3:0] r, er; bit cons;
    for (int i = 0; i < 2; i++) begin
      model_a(1, ed, ev, er, cons);
      read_x(1'b0, 8'h11, d, v, r);
    end
    rst = 1'b0;
    bus_a.gpio_in = gword(1'b0, 8'h30);
    #1;
    checks++; if (s_ready_a !== 4'h0) begin errors++; $display("FAIL t6_ready: got %b expected 0", s_ready_a); end
    checks++; if (bus_a.valid !== 1'b1 || bus_a.gpio_out[31:16] !== 16'h0) begin errors++; $display("FAIL t6_bstat: got %h/%b expected 0000xxxx/1", bus_a.gpio_out, bus_a.valid); end
    for (int k = 0; k < 4; k++) pos_a[k] = 0;
    under_m = 0; last_a = '0;
    bus_a.gpio_in = gword(1'b1, 8'h11);
    @(negedge clk);
    rst = 1'b1;
    model_a(1, ed, ev, er, cons);
    @(posedge clk); #1;
    checks++; if (bus_a.gpio_out !== word_a[1][31:0] || bus_a.valid !== 1'b1) begin errors++; $display("FAIL t6_release_read: got %h/%b expected %h/1", bus_a.gpio_out, bus_a.valid, word_a[1][31:0]); end
    @(negedge clk);
    bus_a.gpio_in = gword(1'b0, 8'h11);
    @(posedge clk); @(negedge clk);
    model_a(1, ed, ev, er, cons);
    read_x(1'b0, 8'h11, d, v, r);
    checks++; if (d !== word_a[1][63:32]) begin errors++; $display("FAIL t6_beat1: got %h expected %h", d, word_a[1][63:32]); end
  endtask

  task automatic test_stat_unmapped();
    logic [31:0] d; logic v; logic [3:0] r;
    bus_a.gpio_in = gword(1'b0, 8'h25);
    bus_b.gpio_in = gword(1'b0, 8'h20);
    #1;
    checks++; if (bus_a.gpio_out !== stat_a[5*32 +: 32] || bus_a.valid !== 1'b1) begin errors++; $display("FAIL stat5: got %h expected %h", bus_a.gpio_out, stat_a[5*32 +: 32]); end
    checks++; if (bus_b.gpio_out !== stat_b) begin errors++; $display("FAIL stat_b0: got %h expected %h", bus_b.gpio_out, stat_b); end
    bus_a.gpio_in = gword(1'b0, 8'h3F);
    #1;
    checks++; if (bus_a.gpio_out !== 32'h0 || bus_a.valid !== 1'b1) begin errors++; $display("FAIL unmapped: got %h/%b expected 0/1", bus_a.gpio_out, bus_a.valid); end
    @(negedge clk);
    read_x(1'b0, 8'h3F, d, v, r);
    checks++; if (d !== 32'h0 || v !== 1'b1 || r !== 4'h0) begin errors++; $display("FAIL unmapped_req: got %h/%b/%b expected 0/1/0", d, v, r); end
  endtask

  task automatic test_random();
    logic [31:0] d, ed; logic v, ev; logic [3:0] r, er; bit cons; int op, k;
    for (int n = 0; n < 120; n++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
        model_flush();
        read_x(1'b0, 8'h31, d, v, r);
        checks++; if (v !== 1'b1 || r !== 4'h0) begin errors++; $display("FAIL rnd_flush[%0d]: got %b/%b expected 1/0", n, v, r); end
      end else if (op == 1) begin
        bus_a.gpio_in = gword(1'b0, 8'h30);
        #1;
        checks++; if (bus_a.gpio_out !== exp_bstat()) begin errors++; $display("FAIL rnd_bstat[%0d]: got %h expected %h", n, bus_a.gpio_out, exp_bstat()); end
        @(negedge clk);
      end else begin
        k = $urandom_range(0, 3);
        model_a(k, ed, ev, er, cons);
        read_x(1'b0, 8'(8'h10 + k), d, v, r);
        checks++; if (d !== ed || v !== ev || r !== er) begin errors++; $display("FAIL rnd_read[%0d] ch%0d: got %h/%b/%b expected %h/%b/%b", n, k, d, v, r, ed, ev, er); end
        if (cons) new_word_a(k, $urandom_range(0, 3) != 0);
        else if (!pres_a[k] && $urandom_range(0, 1) == 1) new_word_a(k, 1'b1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) stat_a[i*32 +: 32] = $urandom;
    stat_b = $urandom;
    test_reset();
    test_single_channel_beats();
    test_underrun();
    test_flush();
    test_width40();
    test_hold();
    test_reset_mid_word();
    test_stat_unmapped();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
